// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_pkg
//  Description : Shared opcode and microstep constants plus the strobe bundle
//                type for the NSC-8 control sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_sequencer_pkg;

  // Opcodes (IR upper nibble)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Microstep encodings
  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  // One bit per datapath strobe
  typedef struct packed {
    logic pc_count;
    logic pc_jump;
    logic pc_output_enable;
    logic mar_load;
    logic ram_output_enable;
    logic ram_write;
    logic ir_load;
    logic ir_output_enable;
    logic a_load;
    logic a_output_enable;
    logic b_load;
    logic alu_output_enable;
    logic alu_subtract;
    logic flags_load;
    logic out_load;
  } strobes_t;

endpackage
`default_nettype wire

// File: rtl/control_sequencer_step_counter.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_step_counter
//  Description : Microstep counter. Advances when enabled, clears at the end
//                of an instruction or after the last legal step, freezes on
//                halt, and recovers from any illegal value on the next clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer_step_counter #(
  parameter int STEP_WIDTH = 3,
  parameter int LAST_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  freeze,
  output logic [STEP_WIDTH-1:0] step
);

  localparam logic [STEP_WIDTH-1:0] C_LAST = STEP_WIDTH'(LAST_STEP);

  logic [STEP_WIDTH-1:0] r_step;

  // Step register: illegal values self-correct regardless of enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step <= '0;
    end else if (r_step > C_LAST) begin
      r_step <= '0;
    end else if (enable && !freeze) begin
      if (clear || (r_step == C_LAST)) begin
        r_step <= '0;
      end else begin
        r_step <= r_step + STEP_WIDTH'(1);
      end
    end
  end

  assign step = r_step;

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : NSC-8 microstep controller. Steps through fetch/execute
//                T-states and decodes (step, opcode, flags) into datapath
//                strobes, gated by active & run_enable & ~halted.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3,
  parameter int LAST_STEP    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run_enable,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    carry_flag,
  input  logic                    zero_flag,
  output logic [STEP_WIDTH-1:0]   step,
  output logic                    halted,
  output logic                    pc_count,
  output logic                    pc_jump,
  output logic                    pc_output_enable,
  output logic                    mar_load,
  output logic                    ram_output_enable,
  output logic                    ram_write,
  output logic                    ir_load,
  output logic                    ir_output_enable,
  output logic                    a_load,
  output logic                    a_output_enable,
  output logic                    b_load,
  output logic                    alu_output_enable,
  output logic                    alu_subtract,
  output logic                    flags_load,
  output logic                    out_load
);

  logic                  r_active;
  logic                  r_halted;
  logic                  w_run;
  logic                  w_end;
  logic                  w_halt_now;
  logic [STEP_WIDTH-1:0] w_step;
  strobes_t              w_dec;
  strobes_t              w_strb;

  assign w_run = r_active && run_enable && !r_halted;

  // Halt freezes the step in T2 so the counter is not advanced on that edge
  control_sequencer_step_counter #(
    .STEP_WIDTH (STEP_WIDTH),
    .LAST_STEP  (LAST_STEP)
  ) u_step_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (w_run && !w_halt_now),
    .clear   (w_end),
    .freeze  (r_halted),
    .step    (w_step)
  );

  // Active goes high on the first clock after reset release; halted latches on HLT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_run && w_halt_now) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Strobe decoder: raw per-step strobes plus end-of-instruction and halt detect
  always_comb begin
    w_dec      = '0;
    w_end      = 1'b0;
    w_halt_now = 1'b0;
    case (w_step)
      T0: begin
        w_dec.pc_output_enable = 1'b1;
        w_dec.mar_load         = 1'b1;
      end
      T1: begin
        w_dec.ram_output_enable = 1'b1;
        w_dec.ir_load           = 1'b1;
        w_dec.pc_count          = 1'b1;
      end
      T2: begin
        w_end = 1'b1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_dec.ir_output_enable = 1'b1;
            w_dec.mar_load         = 1'b1;
            w_end                  = 1'b0;
          end
          OP_LDI: begin
            w_dec.ir_output_enable = 1'b1;
            w_dec.a_load           = 1'b1;
          end
          OP_JMP: begin
            w_dec.ir_output_enable = 1'b1;
            w_dec.pc_jump          = 1'b1;
          end
          OP_JC: begin
            w_dec.ir_output_enable = carry_flag;
            w_dec.pc_jump          = carry_flag;
          end
          OP_JZ: begin
            w_dec.ir_output_enable = zero_flag;
            w_dec.pc_jump          = zero_flag;
          end
          OP_OUT: begin
            w_dec.a_output_enable = 1'b1;
            w_dec.out_load        = 1'b1;
          end
          OP_HLT: begin
            w_halt_now = 1'b1;
            w_end      = 1'b0;
          end
          default: begin
            w_end = 1'b1;
          end
        endcase
      end
      T3: begin
        w_end = 1'b1;
        case (opcode)
          OP_LDA: begin
            w_dec.ram_output_enable = 1'b1;
            w_dec.a_load            = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_dec.ram_output_enable = 1'b1;
            w_dec.b_load            = 1'b1;
            w_dec.alu_subtract      = (opcode == OP_SUB);
            w_end                   = 1'b0;
          end
          OP_STA: begin
            w_dec.a_output_enable = 1'b1;
            w_dec.ram_write       = 1'b1;
          end
          default: begin
            w_end = 1'b1;
          end
        endcase
      end
      T4: begin
        w_end = 1'b1;
        if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
          w_dec.alu_output_enable = 1'b1;
          w_dec.a_load            = 1'b1;
          w_dec.flags_load        = 1'b1;
          w_dec.alu_subtract      = (opcode == OP_SUB);
        end
      end
      default: begin
        w_end = 1'b1;
      end
    endcase
  end

  // Output gating: nothing reaches the datapath unless actively running
  always_comb begin
    w_strb = w_run ? w_dec : '0;
  end

  assign step              = w_step;
  assign halted            = r_halted;
  assign pc_count          = w_strb.pc_count;
  assign pc_jump           = w_strb.pc_jump;
  assign pc_output_enable  = w_strb.pc_output_enable;
  assign mar_load          = w_strb.mar_load;
  assign ram_output_enable = w_strb.ram_output_enable;
  assign ram_write         = w_strb.ram_write;
  assign ir_load           = w_strb.ir_load;
  assign ir_output_enable  = w_strb.ir_output_enable;
  assign a_load            = w_strb.a_load;
  assign a_output_enable   = w_strb.a_output_enable;
  assign b_load            = w_strb.b_load;
  assign alu_output_enable = w_strb.alu_output_enable;
  assign alu_subtract      = w_strb.alu_subtract;
  assign flags_load        = w_strb.flags_load;
  assign out_load          = w_strb.out_load;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Scoreboard bench for control_sequencer. Each cycle drives
//                inputs, pushes the expected strobes/step/halted, then pops
//                and compares against the DUT before the next rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  // Strobe bit positions in the packed observation vector
  localparam logic [14:0] M_PCC  = 15'h4000;
  localparam logic [14:0] M_PCJ  = 15'h2000;
  localparam logic [14:0] M_PCOE = 15'h1000;
  localparam logic [14:0] M_MAR  = 15'h0800;
  localparam logic [14:0] M_RAMO = 15'h0400;
  localparam logic [14:0] M_RAMW = 15'h0200;
  localparam logic [14:0] M_IRLD = 15'h0100;
  localparam logic [14:0] M_IROE = 15'h0080;
  localparam logic [14:0] M_ALD  = 15'h0040;
  localparam logic [14:0] M_AOE  = 15'h0020;
  localparam logic [14:0] M_BLD  = 15'h0010;
  localparam logic [14:0] M_ALUO = 15'h0008;
  localparam logic [14:0] M_SUB  = 15'h0004;
  localparam logic [14:0] M_FLG  = 15'h0002;
  localparam logic [14:0] M_OUT  = 15'h0001;
  localparam logic [14:0] M_NONE = 15'h0000;

  typedef struct {
    logic [14:0] strb;
    logic [2:0]  step;
    logic        halt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, run_enable, carry_flag, zero_flag;
  logic [3:0] opcode;
  logic [2:0] step;
  logic halted;
  logic pc_count, pc_jump, pc_output_enable, mar_load, ram_output_enable, ram_write;
  logic ir_load, ir_output_enable, a_load, a_output_enable, b_load;
  logic alu_output_enable, alu_subtract, flags_load, out_load;
  logic [14:0] act_strb;
  logic [3:0]  oe_vec;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  control_sequencer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .run_enable        (run_enable),
    .opcode            (opcode),
    .carry_flag        (carry_flag),
    .zero_flag         (zero_flag),
    .step              (step),
    .halted            (halted),
    .pc_count          (pc_count),
    .pc_jump           (pc_jump),
    .pc_output_enable  (pc_output_enable),
    .mar_load          (mar_load),
    .ram_output_enable (ram_output_enable),
    .ram_write         (ram_write),
    .ir_load           (ir_load),
    .ir_output_enable  (ir_output_enable),
    .a_load            (a_load),
    .a_output_enable   (a_output_enable),
    .b_load            (b_load),
    .alu_output_enable (alu_output_enable),
    .alu_subtract      (alu_subtract),
    .flags_load        (flags_load),
    .out_load          (out_load)
  );

  always #5 clk = ~clk;

  assign act_strb = {pc_count, pc_jump, pc_output_enable, mar_load, ram_output_enable,
                     ram_write, ir_load, ir_output_enable, a_load, a_output_enable,
                     b_load, alu_output_enable, alu_subtract, flags_load, out_load};
  assign oe_vec   = {pc_output_enable, ram_output_enable, ir_output_enable,
                     a_output_enable | alu_output_enable};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: drive at negedge, push expectation, compare just after settling
  task automatic cyc(input logic rst, input logic run, input logic [3:0] op,
                     input logic cf, input logic zf, input logic [14:0] e_strb,
                     input logic [2:0] e_step, input logic e_halt, input string tag);
    exp_t e;
    @(negedge clk);
    reset_n    = rst;
    run_enable = run;
    opcode     = op;
    carry_flag = cf;
    zero_flag  = zf;
    sb.push_back('{e_strb, e_step, e_halt});
    #1;
    e = sb.pop_front();
    check_val({tag, "_strobes"}, {17'd0, act_strb}, {17'd0, e.strb});
    check_val({tag, "_step"}, {29'd0, step}, {29'd0, e.step});
    check_val({tag, "_halted"}, {31'd0, halted}, {31'd0, e.halt});
    check_val({tag, "_oe_onehot"}, {31'd0, ($countones(oe_vec) <= 1) && !(pc_count && pc_jump)}, 32'd1);
  endtask

  // Fetch then execute; flags are the inverse during fetch so T2 sees a fresh change
  task automatic instr(input logic [3:0] op, input logic cf, input logic zf, input int n,
                       input logic [14:0] e2, input logic [14:0] e3, input logic [14:0] e4,
                       input string tag);
    cyc(1'b1, 1'b1, op, ~cf, ~zf, M_PCOE | M_MAR, 3'd0, 1'b0, {tag, "_T0"});
    cyc(1'b1, 1'b1, op, ~cf, ~zf, M_RAMO | M_IRLD | M_PCC, 3'd1, 1'b0, {tag, "_T1"});
    if (n >= 1) cyc(1'b1, 1'b1, op, cf, zf, e2, 3'd2, 1'b0, {tag, "_T2"});
    if (n >= 2) cyc(1'b1, 1'b1, op, cf, zf, e3, 3'd3, 1'b0, {tag, "_T3"});
    if (n >= 3) cyc(1'b1, 1'b1, op, cf, zf, e4, 3'd4, 1'b0, {tag, "_T4"});
  endtask

  initial begin
    reset_n = 1'b0; run_enable = 1'b1; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;

    // Reset state and the single inactive cycle after release
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, M_NONE, 3'd0, 1'b0, "reset0");
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, M_NONE, 3'd0, 1'b0, "reset1");
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, M_NONE, 3'd0, 1'b0, "inactive");

    instr(4'h1, 1'b0, 1'b0, 2, M_IROE | M_MAR, M_RAMO | M_ALD, M_NONE, "lda");
    instr(4'h2, 1'b0, 1'b0, 3, M_IROE | M_MAR, M_RAMO | M_BLD, M_ALUO | M_ALD | M_FLG, "add");
    instr(4'h3, 1'b0, 1'b0, 3, M_IROE | M_MAR, M_RAMO | M_BLD | M_SUB,
          M_ALUO | M_ALD | M_FLG | M_SUB, "sub");
    instr(4'h4, 1'b0, 1'b0, 2, M_IROE | M_MAR, M_AOE | M_RAMW, M_NONE, "sta");
    instr(4'h5, 1'b0, 1'b0, 1, M_IROE | M_ALD, M_NONE, M_NONE, "ldi");
    instr(4'h6, 1'b0, 1'b0, 1, M_IROE | M_PCJ, M_NONE, M_NONE, "jmp");
    instr(4'h7, 1'b0, 1'b0, 1, M_NONE, M_NONE, M_NONE, "jc_nc");
    instr(4'h7, 1'b1, 1'b0, 1, M_IROE | M_PCJ, M_NONE, M_NONE, "jc_c");
    instr(4'h8, 1'b0, 1'b0, 1, M_NONE, M_NONE, M_NONE, "jz_nz");
    instr(4'h8, 1'b0, 1'b1, 1, M_IROE | M_PCJ, M_NONE, M_NONE, "jz_z");
    instr(4'hE, 1'b0, 1'b0, 1, M_AOE | M_OUT, M_NONE, M_NONE, "out");
    instr(4'h0, 1'b0, 1'b0, 1, M_NONE, M_NONE, M_NONE, "nop");
    instr(4'hB, 1'b0, 1'b0, 1, M_NONE, M_NONE, M_NONE, "op_b");

    // Pause inside T1: pc_count must appear exactly once after resume
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, M_PCOE | M_MAR, 3'd0, 1'b0, "p1_T0");
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, M_NONE, 3'd1, 1'b0, "p1_hold0");
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, M_NONE, 3'd1, 1'b0, "p1_hold1");
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, M_RAMO | M_IRLD | M_PCC, 3'd1, 1'b0, "p1_T1");
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, M_NONE, 3'd2, 1'b0, "p1_T2");

    // Pause during T3 of ADD for three clocks
    instr(4'h2, 1'b0, 1'b0, 1, M_IROE | M_MAR, M_NONE, M_NONE, "padd");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, M_NONE, 3'd3, 1'b0, "padd_hold");
    cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, M_RAMO | M_BLD, 3'd3, 1'b0, "padd_T3");
    cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, M_ALUO | M_ALD | M_FLG, 3'd4, 1'b0, "padd_T4");

    // Reset in the middle of LDA restarts the fetch at T0
    instr(4'h1, 1'b0, 1'b0, 1, M_IROE | M_MAR, M_NONE, M_NONE, "rlda");
    cyc(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, M_NONE, 3'd0, 1'b0, "rlda_rst");
    cyc(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, M_NONE, 3'd0, 1'b0, "rlda_inact");
    instr(4'h5, 1'b0, 1'b0, 1, M_IROE | M_ALD, M_NONE, M_NONE, "ldi2");

    // HLT freezes everything until reset
    instr(4'hF, 1'b0, 1'b0, 1, M_NONE, M_NONE, M_NONE, "hlt");
    for (int i = 0; i < 11; i++)
      cyc(1'b1, (i % 2) == 0, 4'hF, 1'b1, 1'b1, M_NONE, 3'd2, 1'b1, "hlt_hold");
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, M_NONE, 3'd0, 1'b0, "hlt_rst");
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, M_NONE, 3'd0, 1'b0, "hlt_inact");
    instr(4'h0, 1'b0, 1'b0, 1, M_NONE, M_NONE, M_NONE, "post_hlt");
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, M_PCOE | M_MAR, 3'd0, 1'b0, "final_T0");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
